// File: rtl/karatsuba_pkg.sv
// Shared types and width helpers for the sequential Karatsuba multiplier.
package karatsuba_pkg;

  localparam int unsigned DEF_N   = 16;
  localparam int unsigned HALF    = DEF_N / 2;
  localparam int unsigned SUMW    = HALF + 1;
  localparam int unsigned PRODW   = DEF_N + 2;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    P_HI    = 3'd1,
    P_LO    = 3'd2,
    P_MID   = 3'd3,
    COMBINE = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/karatsuba_seq_ctrl_if.sv
// Operand/result handshake bundle for karatsuba_seq_ctrl.
interface karatsuba_seq_ctrl_if #(
  parameter int unsigned N = 16
);

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   X;
  logic [N-1:0]   Y;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] Z;
  logic           busy;

  modport master (
    output in_valid, X, Y, out_ready,
    input  in_ready, out_valid, Z, busy
  );

  modport slave (
    input  in_valid, X, Y, out_ready,
    output in_ready, out_valid, Z, busy
  );

endinterface

// File: rtl/kara_half_mult.sv
// Combinational unsigned W x W -> 2W array multiplier built from ripple-carry rows.
module kara_half_mult #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  localparam int unsigned PW = 2 * W;

  logic [PW-1:0] acc;
  logic [PW-1:0] row;
  logic          carry;
  logic          sum;

  // Each partial-product row is folded in through a chain of full-adder cells.
  always_comb begin
    acc   = '0;
    row   = '0;
    carry = 1'b0;
    sum   = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      row   = b[i] ? (PW'(a) << i) : '0;
      carry = 1'b0;
      for (int j = 0; j < int'(PW); j++) begin
        sum    = acc[j] ^ row[j] ^ carry;
        carry  = (acc[j] & row[j]) | (carry & (acc[j] ^ row[j]));
        acc[j] = sum;
      end
    end
    p = acc;
  end

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// Sequential N x N multiplier: one shared half-width product unit over three Karatsuba steps.
module karatsuba_seq_ctrl
  import karatsuba_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  karatsuba_seq_ctrl_if.slave  bus
);

  localparam int unsigned H  = N / 2;
  localparam int unsigned SW = H + 1;
  localparam int unsigned PW = N + 2;
  localparam int unsigned ZW = 2 * N;

  state_t         state;
  state_t         state_next;

  logic [N-1:0]   xr;
  logic [N-1:0]   yr;
  logic [SW-1:0]  sx;
  logic [SW-1:0]  sy;
  logic [N-1:0]   z1;
  logic [N-1:0]   z2;
  logic [PW-1:0]  z3;
  logic [ZW-1:0]  z_r;

  logic           in_ready_r;
  logic           out_valid_r;
  logic           busy_r;

  logic [SW-1:0]  pa;
  logic [SW-1:0]  pb;
  logic [PW-1:0]  prod;
  logic [PW-1:0]  mid_c;
  logic [ZW-1:0]  z_c;

  kara_half_mult #(.W(SW)) u_mult (
    .a (pa),
    .b (pb),
    .p (prod)
  );

  // Next-state and product-unit operand select.
  always_comb begin
    state_next = state;
    pa         = '0;
    pb         = '0;
    case (state)
      IDLE:    if (bus.in_valid) state_next = P_HI;
      P_HI: begin
        pa         = {1'b0, xr[N-1:H]};
        pb         = {1'b0, yr[N-1:H]};
        state_next = P_LO;
      end
      P_LO: begin
        pa         = {1'b0, xr[H-1:0]};
        pb         = {1'b0, yr[H-1:0]};
        state_next = P_MID;
      end
      P_MID: begin
        pa         = sx;
        pb         = sy;
        state_next = COMBINE;
      end
      COMBINE: state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Cross term Xh*Yl + Xl*Yh; it never goes negative, so the top bit stays zero.
  assign mid_c = z3 - PW'(z1) - PW'(z2);
  assign z_c   = {z1, N'(0)} + (ZW'(mid_c) << H) + ZW'(z2);

  // State register and status flags, registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state       <= state_next;
      in_ready_r  <= (state_next == IDLE);
      out_valid_r <= (state_next == DONE);
      busy_r      <= (state_next != IDLE);
    end
  end

  // Operand, partial-product and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xr  <= '0;
      yr  <= '0;
      sx  <= '0;
      sy  <= '0;
      z1  <= '0;
      z2  <= '0;
      z3  <= '0;
      z_r <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          xr <= bus.X;
          yr <= bus.Y;
          sx <= SW'(bus.X[N-1:H]) + SW'(bus.X[H-1:0]);
          sy <= SW'(bus.Y[N-1:H]) + SW'(bus.Y[H-1:0]);
        end
        P_HI:    z1  <= prod[N-1:0];
        P_LO:    z2  <= prod[N-1:0];
        P_MID:   z3  <= prod;
        COMBINE: z_r <= z_c;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.Z         = z_r;

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Directed self-checking bench for karatsuba_seq_ctrl.
module tb_karatsuba_seq_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  karatsuba_seq_ctrl_if #(.N(16)) bus ();

  karatsuba_seq_ctrl #(.N(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full transaction with out_ready held high: accept at E0, result after E4, handshake at E5.
  task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic [31:0] exp);
    bus.X = x; bus.Y = y; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check_eq({tag, "_e0_in_ready"}, 64'(bus.in_ready), 64'd0);
    check_eq({tag, "_e0_busy"}, 64'(bus.busy), 64'd1);
    tick(); tick(); tick();
    check_eq({tag, "_e3_out_valid"}, 64'(bus.out_valid), 64'd0);
    check_eq({tag, "_e3_in_ready"}, 64'(bus.in_ready), 64'd0);
    tick();
    check_eq({tag, "_e4_out_valid"}, 64'(bus.out_valid), 64'd1);
    check_eq({tag, "_e4_z"}, 64'(bus.Z), 64'(exp));
    check_eq({tag, "_e4_busy"}, 64'(bus.busy), 64'd1);
    tick();
    check_eq({tag, "_e5_out_valid"}, 64'(bus.out_valid), 64'd0);
    check_eq({tag, "_e5_in_ready"}, 64'(bus.in_ready), 64'd1);
    check_eq({tag, "_e5_busy"}, 64'(bus.busy), 64'd0);
    check_eq({tag, "_e5_z_hold"}, 64'(bus.Z), 64'(exp));
  endtask

  initial begin
    logic [31:0] exp_q [3];
    logic [15:0] xs [3];
    logic [15:0] ys [3];
    int acc_n;
    int res_n;
    int last_t;
    logic pre_ready;

    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.X = '0; bus.Y = '0;
    tick(); tick();
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_z", 64'(bus.Z), 64'd0);
    rst_n = 1'b1;
    tick();

    do_op("zero", 16'h0000, 16'h1234, 32'h0000_0000);
    do_op("carry", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    do_op("generic", 16'h1234, 16'h5678, 32'h0626_0060);

    // Back-pressure: result must hold while new operands are offered.
    bus.X = 16'h00FF; bus.Y = 16'h0100; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check_eq("bp_e4_out_valid", 64'(bus.out_valid), 64'd1);
    check_eq("bp_e4_z", 64'(bus.Z), 64'h0000_FF00);
    bus.in_valid = 1'b1; bus.X = 16'hAAAA; bus.Y = 16'hAAAA;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("bp_hold_z", 64'(bus.Z), 64'h0000_FF00);
      check_eq("bp_hold_out_valid", 64'(bus.out_valid), 64'd1);
      check_eq("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    check_eq("bp_hs_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("bp_hs_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("bp_hs_z", 64'(bus.Z), 64'h0000_FF00);
    tick();
    check_eq("bp_no_capture_busy", 64'(bus.busy), 64'd0);

    // Reset while P_MID is pending.
    bus.X = 16'h8001; bus.Y = 16'h8001; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rstmid_z", 64'(bus.Z), 64'd0);
    check_eq("rstmid_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rstmid_busy", 64'(bus.busy), 64'd0);
    tick(); tick();
    check_eq("rstmid_idle_out_valid", 64'(bus.out_valid), 64'd0);
    do_op("after_rst", 16'd3, 16'd5, 32'd15);

    // Back-to-back stream with both sides always willing.
    xs[0] = 16'h0002; ys[0] = 16'h0003; exp_q[0] = 32'h0000_0006;
    xs[1] = 16'hFFFF; ys[1] = 16'h0001; exp_q[1] = 32'h0000_FFFF;
    xs[2] = 16'h8000; ys[2] = 16'h8000; exp_q[2] = 32'h4000_0000;
    acc_n = 0; res_n = 0; last_t = 0;
    bus.X = xs[0]; bus.Y = ys[0]; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      pre_ready = bus.in_ready;
      tick();
      if (pre_ready && bus.in_valid) begin
        acc_n++;
        if (acc_n < 3) begin
          bus.X = xs[acc_n]; bus.Y = ys[acc_n];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid && res_n < 3) begin
        check_eq("b2b_z", 64'(bus.Z), 64'(exp_q[res_n]));
        if (res_n > 0) check_eq("b2b_spacing", 64'(t - last_t), 64'd6);
        last_t = t;
        res_n++;
      end
    end
    check_eq("b2b_result_count", 64'(res_n), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/karatsuba_seq_ctrl.md
Name: karatsuba_seq_ctrl

Overview:
- Sequential N x N unsigned multiplier controller.
- Shares a single half-width product unit across the three Karatsuba partial products: z1 = Xh*Yh, z2 = Xl*Yl, z3 = (Xh+Xl)*(Yh+Yl).
- Combines the three products into the 2N-bit result.
- Area-reduced alternative to the fully combinational recursive multiplier; sits behind a valid/ready operand interface in the datapath.

Parameters:
- N, 16, operand width; even, >= 4.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands X, Y valid.
- in_ready  output  1  block can accept operands.
- X  input  N  multiplicand, unsigned.
- Y  input  N  multiplier, unsigned.
- out_valid  output  1  Z holds a completed product.
- out_ready  input  1  consumer accepts Z.
- Z  output  2N  product X*Y, registered.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; in_ready=1; out_valid=0; busy=0; Z=0.
  - All internal operand and product registers cleared.
- Reset mid-operation aborts the operation immediately. No result is produced and the captured operands are discarded.
- FSM states: IDLE, P_HI, P_LO, P_MID, COMBINE, DONE.
- IDLE:
  - in_ready=1.
  - On edge E0 with in_valid=1, register X and Y, and register sx=Xh+Xl and sy=Yh+Yl (each N/2+1 bits, carry kept). Go to P_HI.
  - in_valid=0: stay in IDLE.
- P_HI: product unit inputs {0,Xh},{0,Yh}; register z1 (N bits). Go to P_LO.
- P_LO: inputs {0,Xl},{0,Yl}; register z2 (N bits). Go to P_MID.
- P_MID: inputs sx, sy; register z3 (N+2 bits). Go to COMBINE.
- COMBINE:
  - mid = z3 - z1 - z2, N+1 bits; always non-negative, any borrow-out ignored.
  - Z <= (z1<<N) + (mid<<(N/2)) + z2, truncated to 2N bits; no overflow is possible.
  - Go to DONE.
- DONE:
  - out_valid=1; Z held stable.
  - out_valid=1 and out_ready=1 at an edge: go to IDLE. out_valid drops and in_ready rises after that edge.
  - out_ready=0: hold DONE indefinitely; Z and out_valid do not change.
- Latency: operands accepted at E0 produce out_valid=1 after E4. The earliest output handshake is at E5 and the next acceptance at E6, so peak throughput is one product per 6 cycles.
- in_ready=0 in every non-IDLE state. in_valid and the X/Y values are ignored outside IDLE.
- out_ready is ignored outside DONE.
- Z keeps its last value after the output handshake; only the next COMBINE or a reset changes it.
- Product unit: purely combinational, (N/2+1) x (N/2+1) -> N+2 bits. Its inputs are muxed by state and are 0 in IDLE, COMBINE and DONE.

Decomposition:
- Shared package/include karatsuba_pkg:
  - FSM state encoding as localparams: IDLE=0, P_HI=1, P_LO=2, P_MID=3, COMBINE=4, DONE=5; 3-bit state width.
  - Width helper constants: HALF=N/2, SUMW=N/2+1, PRODW=N+2.
- One sub-module, kara_half_mult: combinational unsigned SUMW x SUMW -> PRODW multiplier, built from the team's full_adder/RCA cells.
- Controller, operand/product registers and combine adders stay in karatsuba_seq_ctrl.

Test Plan:
- Zero operand, out_ready=1:
  - Stimulus: after reset, X=0x0000, Y=0x1234, in_valid pulse at E0.
  - Required: out_valid rises after E4 with Z=0x00000000; busy high E0..E5; in_ready low E0..E4.
- Full-width carries:
  - Stimulus: X=0xFFFF, Y=0xFFFF (sx=sy=0x1FE).
  - Required: Z=0xFFFE0001.
- Generic product:
  - Stimulus: X=0x1234, Y=0x5678.
  - Required: Z=0x06260060.
- Back-pressure:
  - Stimulus: X=0x00FF, Y=0x0100; out_ready held 0 for 3 cycles after out_valid rises; in_valid=1 with X=0xAAAA during that window.
  - Required: Z stays 0x0000FF00 and out_valid stays 1; the new operands are not captured; in_ready=0 until the cycle after the handshake.
- Reset mid-operation:
  - Stimulus: start X=0x8001, Y=0x8001; drive rst_n=0 at the E2 edge (state P_MID pending).
  - Required: after that edge state=IDLE, out_valid=0, Z=0, in_ready=1. A following X=3, Y=5 gives Z=15 with normal latency.
- Back-to-back throughput:
  - Stimulus: in_valid and out_ready held 1; operand stream (2,3), (0xFFFF,1), (0x8000,0x8000).
  - Required: results 6, 0x0000FFFF, 0x40000000 appear in order, spaced exactly 6 cycles apart.
